signed_bcd_display: RTL and testbench



---
 rtl/display_pkg.sv | 39 +++
 rtl/bcd_seg_decode.sv | 27 ++
 rtl/signed_bcd_display.sv | 140 ++++++++++++++
 tb/tb_signed_bcd_display.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants, FSM state type and parameter-check helper for the
// signed BCD seven-segment display block.
package display_pkg;

  // Segment patterns ordered a..g (MSB = a), active-low.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b1111110;
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    UPDATE  = 2'd2
  } state_t;

  // Number of decimal digits needed to print 2^width - 1.
  function automatic int dec_digits(input int width);
    longint unsigned v;
    int n;
    v = (longint'(1) << width) - 1;
    n = 1;
    v = v / 10;
    while (v != 0) begin
      n = n + 1;
      v = v / 10;
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_seg_decode.sv
// Combinational BCD nibble to active-low seven-segment pattern (a..g).
// Out-of-range nibbles (>9) decode to blank.
module bcd_seg_decode
  import display_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0: o_seg = SEG_0;
      4'd1: o_seg = SEG_1;
      4'd2: o_seg = SEG_2;
      4'd3: o_seg = SEG_3;
      4'd4: o_seg = SEG_4;
      4'd5: o_seg = SEG_5;
      4'd6: o_seg = SEG_6;
      4'd7: o_seg = SEG_7;
      4'd8: o_seg = SEG_8;
      4'd9: o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/signed_bcd_display.sv
// Signed/unsigned binary to seven-segment display via serial double-dabble.
// Define FLOAT_SIGN_EN to place the minus next to the leading numeral.
module signed_bcd_display
  import display_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  is_signed,
  input  logic [WIDTH-1:0]      X,
  output logic                  busy,
  output logic                  done,
  output logic [7*DIGITS-1:0]   HEX
);

  localparam int N  = DIGITS - 1;
  localparam int BW = 4 * N;
  localparam int CW = $clog2(WIDTH + 1);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("signed_bcd_display: WIDTH must be in 2..32");
  end
  if (DIGITS < dec_digits(WIDTH) + 1) begin : g_bad_digits
    $error("signed_bcd_display: DIGITS too small for WIDTH plus sign");
  end

  state_t              r_state;
  logic                r_sign;
  logic [WIDTH-1:0]    r_mag;
  logic [BW-1:0]       r_bcd;
  logic [CW-1:0]       r_cnt;
  logic                r_busy;
  logic                r_done;
  logic [7*DIGITS-1:0] r_hex;

  logic                w_sign_in;
  logic [WIDTH-1:0]    w_mag_in;
  logic [BW-1:0]       w_adj;
  logic [N-1:0]        w_nz;
  logic [N-1:0]        w_lead;
  logic [DIGITS-1:0]   w_show;
  logic [DIGITS-1:0]   w_minus;
  logic [7*N-1:0]      w_dec;
  logic [7*DIGITS-1:0] w_hex;

  assign w_sign_in = is_signed & X[WIDTH-1];
  assign w_mag_in  = w_sign_in ? (-X) : X;

  for (genvar gi = 0; gi < N; gi++) begin : g_nib
    logic [3:0] w_nib;
    assign w_nib = r_bcd[4*gi +: 4];
    assign w_adj[4*gi +: 4] = (w_nib >= 4'd5) ? (w_nib + 4'd3) : w_nib;
    assign w_nz[gi] = |w_nib;
    bcd_seg_decode u_dec (
      .i_bcd (w_nib),
      .o_seg (w_dec[7*gi +: 7])
    );
    // w_lead: some nibble at this position or above is non-zero.
    if (gi == N - 1) begin : g_top
      assign w_lead[gi] = w_nz[gi];
    end else begin : g_mid
      assign w_lead[gi] = w_nz[gi] | w_lead[gi+1];
    end
    if (gi == 0) begin : g_units
      assign w_show[gi] = 1'b1;
    end else begin : g_upper
      assign w_show[gi] = w_lead[gi];
    end
  end
  assign w_show[DIGITS-1] = 1'b0;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_pos
`ifdef FLOAT_SIGN_EN
    if (gi == 0) begin : g_no_minus
      assign w_minus[gi] = 1'b0;
    end else begin : g_float
      assign w_minus[gi] = r_sign & w_show[gi-1] & ~w_show[gi];
    end
`else
    if (gi == DIGITS - 1) begin : g_fixed
      assign w_minus[gi] = r_sign;
    end else begin : g_no_minus
      assign w_minus[gi] = 1'b0;
    end
`endif
    if (gi < N) begin : g_num
      assign w_hex[7*gi +: 7] = w_show[gi]  ? w_dec[7*gi +: 7] :
                                w_minus[gi] ? SEG_MINUS : SEG_BLANK;
    end else begin : g_sign
      assign w_hex[7*gi +: 7] = w_minus[gi] ? SEG_MINUS : SEG_BLANK;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sign  <= 1'b0;
      r_mag   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hex   <= {DIGITS{SEG_BLANK}};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sign  <= w_sign_in;
            r_mag   <= w_mag_in;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= CONVERT;
          end
        end
        CONVERT: begin
          {r_bcd, r_mag} <= {w_adj[BW-2:0], r_mag, 1'b0};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) r_state <= UPDATE;
        end
        UPDATE: begin
          r_hex   <= w_hex;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign HEX  = r_hex;

endmodule

// File: tb/tb_signed_bcd_display.sv
// Self-checking bench for signed_bcd_display at 8-bit/4-digit and 16-bit/6-digit.
// Expected displays come from a division-based decimal model in the bench.
module tb_signed_bcd_display;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start8, sg8, busy8, done8;
  logic [7:0]  x8;
  logic [27:0] hex8;
  logic        start16, sg16, busy16, done16;
  logic [15:0] x16;
  logic [41:0] hex16;

  int total = 0;
  int bad   = 0;
  logic [41:0] q8[$];
  logic [41:0] q16[$];

  signed_bcd_display #(.WIDTH(8), .DIGITS(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .is_signed(sg8), .X(x8),
    .busy(busy8), .done(done8), .HEX(hex8)
  );

  signed_bcd_display #(.WIDTH(16), .DIGITS(6)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .is_signed(sg16), .X(x16),
    .busy(busy16), .done(done16), .HEX(hex16)
  );

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [41:0] exp_hex(input int w, input int nd,
                                          input logic [31:0] x, input logic s);
    longint unsigned full, v;
    logic neg;
    int d[6];
    int nnum, mpos;
    logic [41:0] r;
    full = longint'(1) << w;
    neg  = s && x[w-1];
    v    = longint'(x) & (full - 1);
    if (neg) v = full - v;
    nnum = 1;
    for (int i = 0; i < 6; i++) begin
      d[i] = int'(v % 10);
      v = v / 10;
      if (d[i] != 0) nnum = i + 1;
    end
`ifdef FLOAT_SIGN_EN
    mpos = nnum;
`else
    mpos = nd - 1;
`endif
    r = '1;
    for (int i = 0; i < nd; i++) begin
      if (i < nnum) r[7*i +: 7] = seg_of(d[i]);
      else if (neg && i == mpos) r[7*i +: 7] = 7'b1111110;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done8(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done8 === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic wait_done16(output int lat);
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (done16 === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic convert8(input logic [7:0] x, input logic s, input string name);
    int lat;
    logic [41:0] e;
    start8 = 1'b1; x8 = x; sg8 = s;
    q8.push_back(exp_hex(8, 4, {24'd0, x}, s));
    tick();
    start8 = 1'b0; x8 = 8'($urandom); sg8 = 1'($urandom);
    total++;
    if (busy8 !== 1'b1) begin
      bad++; $display("FAIL %s_busy: busy=%b expected 1", name, busy8);
    end
    wait_done8(lat);
    total++;
    if (lat != 9) begin
      bad++; $display("FAIL %s_latency: cycles=%0d expected 9", name, lat);
    end
    e = q8.pop_front();
    total++;
    if (hex8 !== e[27:0]) begin
      bad++; $display("FAIL %s_hex: hex=%h expected %h", name, hex8, e[27:0]);
    end
    tick();
    total++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      bad++; $display("FAIL %s_idle: done=%b busy=%b expected 0 0", name, done8, busy8);
    end
    $display("conv8 %s: X=%h signed=%b hex=%h latency=%0d", name, x, s, hex8, lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start8 = 1'b0; sg8 = 1'b0; x8 = '0;
    start16 = 1'b0; sg16 = 1'b0; x16 = '0;
    tick(); tick(); tick();
    total++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      bad++; $display("FAIL reset8_ctl: busy=%b done=%b expected 0 0", busy8, done8);
    end
    total++;
    if (hex8 !== {28{1'b1}}) begin
      bad++; $display("FAIL reset8_hex: hex=%h expected fffffff", hex8);
    end
    total++;
    if (busy16 !== 1'b0 || done16 !== 1'b0) begin
      bad++; $display("FAIL reset16_ctl: busy=%b done=%b expected 0 0", busy16, done16);
    end
    total++;
    if (hex16 !== {42{1'b1}}) begin
      bad++; $display("FAIL reset16_hex: hex=%h expected all ones", hex16);
    end
    rst_n = 1'b1;
    tick();
    $display("reset: hex8=%h hex16=%h", hex8, hex16);
  endtask

  task automatic test_values();
    logic [7:0] xs[8] = '{8'hD6, 8'h80, 8'h80, 8'hFF, 8'h00, 8'h00, 8'h2A, 8'h7F};
    logic       ss[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) convert8(xs[i], ss[i], $sformatf("val%0d", i));
  endtask

  task automatic test_busy_ignore();
    int lat, ndone;
    logic [41:0] e;
    start8 = 1'b1; x8 = 8'd7; sg8 = 1'b0;
    q8.push_back(exp_hex(8, 4, 32'd7, 1'b0));
    tick();
    start8 = 1'b0;
    tick();
    start8 = 1'b1; x8 = 8'd5; sg8 = 1'b1;
    tick();
    start8 = 1'b0;
    wait_done8(lat);
    total++;
    if (lat != 7) begin
      bad++; $display("FAIL busy_ignore_latency: cycles=%0d expected 7", lat);
    end
    e = q8.pop_front();
    total++;
    if (hex8 !== e[27:0]) begin
      bad++; $display("FAIL busy_ignore_hex: hex=%h expected %h", hex8, e[27:0]);
    end
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done8 === 1'b1) ndone++;
    end
    total++;
    if (ndone != 0) begin
      bad++; $display("FAIL busy_ignore_extra_done: count=%0d expected 0", ndone);
    end
    $display("busy_ignore: hex=%h extra_done=%0d", hex8, ndone);
  endtask

  task automatic test_reset_mid();
    int ndone;
    start8 = 1'b1; x8 = 8'd99; sg8 = 1'b0;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    total++;
    if (hex8 !== {28{1'b1}}) begin
      bad++; $display("FAIL reset_mid_hex: hex=%h expected fffffff", hex8);
    end
    total++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      bad++; $display("FAIL reset_mid_ctl: busy=%b done=%b expected 0 0", busy8, done8);
    end
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done8 === 1'b1) ndone++;
    end
    total++;
    if (ndone != 0 || hex8 !== {28{1'b1}}) begin
      bad++; $display("FAIL reset_mid_no_done: count=%0d hex=%h expected 0 fffffff", ndone, hex8);
    end
    $display("reset_mid: hex=%h done_count=%0d", hex8, ndone);
    convert8(8'd1, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [41:0] e;
    start8 = 1'b1; x8 = 8'hD6; sg8 = 1'b1;
    q8.push_back(exp_hex(8, 4, 32'hD6, 1'b1));
    tick();
    x8 = 8'h80; sg8 = 1'b0;
    wait_done8(lat);
    total++;
    if (lat != 9) begin
      bad++; $display("FAIL b2b_first_latency: cycles=%0d expected 9", lat);
    end
    e = q8.pop_front();
    total++;
    if (hex8 !== e[27:0]) begin
      bad++; $display("FAIL b2b_first_hex: hex=%h expected %h", hex8, e[27:0]);
    end
    q8.push_back(exp_hex(8, 4, 32'h80, 1'b0));
    tick();
    start8 = 1'b0;
    total++;
    if (busy8 !== 1'b1) begin
      bad++; $display("FAIL b2b_restart: busy=%b expected 1", busy8);
    end
    wait_done8(lat);
    total++;
    if (lat != 9) begin
      bad++; $display("FAIL b2b_second_latency: cycles=%0d expected 9", lat);
    end
    e = q8.pop_front();
    total++;
    if (hex8 !== e[27:0]) begin
      bad++; $display("FAIL b2b_second_hex: hex=%h expected %h", hex8, e[27:0]);
    end
    tick();
    $display("back_to_back: hex=%h", hex8);
  endtask

  task automatic test_wide();
    logic [15:0] xs[4] = '{16'h8000, 16'hFFFF, 16'hFFFF, 16'd1234};
    logic        ss[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int lat;
    logic [41:0] e;
    for (int i = 0; i < 4; i++) begin
      start16 = 1'b1; x16 = xs[i]; sg16 = ss[i];
      q16.push_back(exp_hex(16, 6, {16'd0, xs[i]}, ss[i]));
      tick();
      start16 = 1'b0;
      wait_done16(lat);
      total++;
      if (lat != 17) begin
        bad++; $display("FAIL wide%0d_latency: cycles=%0d expected 17", i, lat);
      end
      e = q16.pop_front();
      total++;
      if (hex16 !== e) begin
        bad++; $display("FAIL wide%0d_hex: hex=%h expected %h", i, hex16, e);
      end
      tick();
      $display("conv16 wide%0d: X=%h signed=%b hex=%h latency=%0d", i, xs[i], ss[i], hex16, lat);
    end
  endtask

  initial begin
    test_reset();
    test_values();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
